// File: rtl/dpram_req_scheduler.sv
// rtl/dpram_req_scheduler.sv - per-port request queues feeding dpram, with A/B write-collision arbitration
// A collision is both heads sharing an address with at least one write; reads never collide.

module dpram_req_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head is forced to zero when empty so idle outputs never show stale entries
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module dpram_req_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid_a,
    output logic                  s_ready_a,
    input  logic [ADDR_WIDTH-1:0] s_addr_a,
    input  logic [DATA_WIDTH-1:0] s_data_a,
    input  logic                  s_we_a,
    input  logic                  s_valid_b,
    output logic                  s_ready_b,
    input  logic [ADDR_WIDTH-1:0] s_addr_b,
    input  logic [DATA_WIDTH-1:0] s_data_b,
    input  logic                  s_we_b,
    output logic                  m_valid_a,
    input  logic                  m_ready_a,
    output logic [ADDR_WIDTH-1:0] m_addr_a,
    output logic [DATA_WIDTH-1:0] m_data_a,
    output logic                  m_we_a,
    output logic                  m_valid_b,
    input  logic                  m_ready_b,
    output logic [ADDR_WIDTH-1:0] m_addr_b,
    output logic [DATA_WIDTH-1:0] m_data_b,
    output logic                  m_we_b,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);
    localparam int ENTRY_W = 1 + DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic {PRIO_A, PRIO_B} prio_t;

    prio_t              prio;
    logic               ready_en;
    logic               lock_a;
    logic               lock_b;
    logic               push_a;
    logic               push_b;
    logic               pop_a;
    logic               pop_b;
    logic               empty_a;
    logic               empty_b;
    logic               full_a;
    logic               full_b;
    logic [ENTRY_W-1:0] head_a;
    logic [ENTRY_W-1:0] head_b;
    logic               collision;
    logic               grant_a;
    logic               grant_b;

    assign s_ready_a = ready_en & ~full_a;
    assign s_ready_b = ready_en & ~full_b;
    assign push_a    = s_valid_a & s_ready_a;
    assign push_b    = s_valid_b & s_ready_b;

    dpram_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_a),
        .push_data ({s_we_a, s_data_a, s_addr_a}),
        .pop       (pop_a),
        .head      (head_a),
        .empty     (empty_a),
        .full      (full_a)
    );

    dpram_req_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_b),
        .push_data ({s_we_b, s_data_b, s_addr_b}),
        .pop       (pop_b),
        .head      (head_b),
        .empty     (empty_b),
        .full      (full_b)
    );

    assign {m_we_a, m_data_a, m_addr_a} = head_a;
    assign {m_we_b, m_data_b, m_addr_b} = head_b;

    assign collision = ~empty_a & ~empty_b & (m_addr_a == m_addr_b) & (m_we_a | m_we_b);

    always_comb begin
        grant_a = ~empty_a;
        grant_b = ~empty_b;
        if (collision) begin
            // A stalled request keeps the port so its head stays stable until accepted
            if (lock_a) begin
                grant_b = 1'b0;
            end else if (lock_b) begin
                grant_a = 1'b0;
            end else if (prio == PRIO_A) begin
                grant_b = 1'b0;
            end else begin
                grant_a = 1'b0;
            end
        end
    end

    assign m_valid_a = grant_a;
    assign m_valid_b = grant_b;
    assign pop_a     = m_valid_a & m_ready_a;
    assign pop_b     = m_valid_b & m_ready_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_en     <= 1'b0;
            prio         <= PRIO_A;
            lock_a       <= 1'b0;
            lock_b       <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            lock_a   <= m_valid_a & ~m_ready_a;
            lock_b   <= m_valid_b & ~m_ready_b;
            if (collision && pop_a) begin
                prio <= PRIO_B;
            end else if (collision && pop_b) begin
                prio <= PRIO_A;
            end
            if (collision && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_dpram_req_scheduler.sv
// tb/tb_dpram_req_scheduler.sv - directed-vector bench for dpram_req_scheduler
module tb_dpram_req_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid_a, s_ready_a, s_we_a;
    logic        s_valid_b, s_ready_b, s_we_b;
    logic [7:0]  s_addr_a, s_data_a, s_addr_b, s_data_b;
    logic        m_valid_a, m_ready_a, m_we_a;
    logic        m_valid_b, m_ready_b, m_we_b;
    logic [7:0]  m_addr_a, m_data_a, m_addr_b, m_data_b;
    logic [15:0] conflict_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dpram_req_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid_a    (s_valid_a),
        .s_ready_a    (s_ready_a),
        .s_addr_a     (s_addr_a),
        .s_data_a     (s_data_a),
        .s_we_a       (s_we_a),
        .s_valid_b    (s_valid_b),
        .s_ready_b    (s_ready_b),
        .s_addr_b     (s_addr_b),
        .s_data_b     (s_data_b),
        .s_we_b       (s_we_b),
        .m_valid_a    (m_valid_a),
        .m_ready_a    (m_ready_a),
        .m_addr_a     (m_addr_a),
        .m_data_a     (m_data_a),
        .m_we_a       (m_we_a),
        .m_valid_b    (m_valid_b),
        .m_ready_b    (m_ready_b),
        .m_addr_b     (m_addr_b),
        .m_data_b     (m_data_b),
        .m_we_b       (m_we_b),
        .conflict_cnt (conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] addr, input logic [7:0] da, input logic [7:0] db);
        s_valid_a = 1'b1; s_addr_a = addr; s_data_a = da; s_we_a = 1'b1;
        s_valid_b = 1'b1; s_addr_b = addr; s_data_b = db; s_we_b = 1'b1;
        step();
        s_valid_a = 1'b0;
        s_valid_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s_valid_a = 0; s_addr_a = 0; s_data_a = 0; s_we_a = 0;
        s_valid_b = 0; s_addr_b = 0; s_data_b = 0; s_we_b = 0;
        m_ready_a = 0; m_ready_b = 0;

        repeat (2) step();
        chk("rst_s_ready_a", s_ready_a, 0);
        chk("rst_s_ready_b", s_ready_b, 0);
        chk("rst_m_valid_a", m_valid_a, 0);
        chk("rst_m_valid_b", m_valid_b, 0);
        chk("rst_cnt", conflict_cnt, 0);
        rst_n = 1'b1;
        step();
        chk("rel_s_ready_a", s_ready_a, 1);
        chk("rel_s_ready_b", s_ready_b, 1);

        // single write on A
        m_ready_a = 1; m_ready_b = 1;
        s_valid_a = 1; s_addr_a = 8'h10; s_data_a = 8'hAA; s_we_a = 1;
        step();
        s_valid_a = 0;
        chk("t1_valid_a", m_valid_a, 1);
        chk("t1_addr_a", m_addr_a, 8'h10);
        chk("t1_data_a", m_data_a, 8'hAA);
        chk("t1_we_a", m_we_a, 1);
        chk("t1_valid_b", m_valid_b, 0);
        step();
        chk("t1_valid_a_done", m_valid_a, 0);
        chk("t1_addr_a_empty", m_addr_a, 0);
        chk("t1_cnt", conflict_cnt, 0);

        // write/write collision, prio A then B
        push_pair(8'h20, 8'h11, 8'h22);
        chk("t2a_valid_a", m_valid_a, 1);
        chk("t2a_valid_b", m_valid_b, 0);
        step();
        chk("t2a_valid_a2", m_valid_a, 0);
        chk("t2a_valid_b2", m_valid_b, 1);
        chk("t2a_data_b2", m_data_b, 8'h22);
        step();
        chk("t2a_cnt", conflict_cnt, 1);
        push_pair(8'h20, 8'h11, 8'h22);
        chk("t2b_valid_a", m_valid_a, 0);
        chk("t2b_valid_b", m_valid_b, 1);
        step();
        chk("t2b_valid_a2", m_valid_a, 1);
        chk("t2b_data_a2", m_data_a, 8'h11);
        chk("t2b_valid_b2", m_valid_b, 0);
        step();
        chk("t2b_cnt", conflict_cnt, 2);

        // read vs write, different addresses
        s_valid_a = 1; s_addr_a = 8'h05; s_we_a = 0;
        s_valid_b = 1; s_addr_b = 8'h06; s_data_b = 8'h66; s_we_b = 1;
        step();
        s_valid_a = 0; s_valid_b = 0;
        chk("t3_valid_a", m_valid_a, 1);
        chk("t3_valid_b", m_valid_b, 1);
        chk("t3_cnt", conflict_cnt, 2);
        step();

        // fill A, then drain
        m_ready_a = 0;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_ready_before_push", s_ready_a, 1);
            s_valid_a = 1; s_addr_a = 8'(8'h40 + i); s_data_a = 8'(i); s_we_a = 1;
            step();
        end
        s_valid_a = 0;
        chk("t4_full_ready", s_ready_a, 0);
        chk("t4_head_data", m_data_a, 1);
        m_ready_a = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("t4_drain_valid", m_valid_a, 1);
            chk("t4_drain_data", m_data_a, 32'(i));
            step();
            if (i == 1) chk("t4_ready_after_pop", s_ready_a, 1);
        end
        chk("t4_empty", m_valid_a, 0);
        chk("t4_cnt", conflict_cnt, 2);

        // one more collision leaves prio on B
        push_pair(8'h20, 8'h11, 8'h22);
        chk("t5p_valid_a", m_valid_a, 1);
        chk("t5p_valid_b", m_valid_b, 0);
        step();
        chk("t5p_valid_b2", m_valid_b, 1);
        step();

        // stalled A keeps the port against a colliding B even though prio is B
        m_ready_a = 0;
        s_valid_a = 1; s_addr_a = 8'h30; s_data_a = 8'h33; s_we_a = 1;
        step();
        s_valid_a = 0;
        chk("t5_c1_valid_a", m_valid_a, 1);
        chk("t5_c1_valid_b", m_valid_b, 0);
        s_valid_b = 1; s_addr_b = 8'h30; s_data_b = 8'h44; s_we_b = 1;
        step();
        s_valid_b = 0;
        chk("t5_c2_valid_a", m_valid_a, 1);
        chk("t5_c2_data_a", m_data_a, 8'h33);
        chk("t5_c2_valid_b", m_valid_b, 0);
        step();
        chk("t5_c3_valid_a", m_valid_a, 1);
        chk("t5_c3_valid_b", m_valid_b, 0);
        step();
        m_ready_a = 1;
        chk("t5_c4_valid_a", m_valid_a, 1);
        chk("t5_c4_valid_b", m_valid_b, 0);
        step();
        chk("t5_c5_valid_a", m_valid_a, 0);
        chk("t5_c5_valid_b", m_valid_b, 1);
        chk("t5_c5_data_b", m_data_b, 8'h44);
        chk("t5_cnt", conflict_cnt, 6);
        step();

        // reset with queued entries
        m_ready_a = 0; m_ready_b = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid_a = 1; s_addr_a = 8'(8'h50 + i); s_we_a = 0;
            s_valid_b = 1; s_addr_b = 8'(8'h60 + i); s_we_b = 0;
            step();
        end
        s_valid_a = 0; s_valid_b = 0;
        chk("t6_queued_a", m_valid_a, 1);
        chk("t6_queued_b", m_valid_b, 1);
        rst_n = 0;
        step();
        chk("t6_rst_valid_a", m_valid_a, 0);
        chk("t6_rst_ready_a", s_ready_a, 0);
        step();
        rst_n = 1;
        step();
        chk("t6_ready_a", s_ready_a, 1);
        chk("t6_ready_b", s_ready_b, 1);
        chk("t6_cnt", conflict_cnt, 0);
        m_ready_a = 1; m_ready_b = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_stale_a", m_valid_a, 0);
            chk("t6_no_stale_b", m_valid_b, 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
